// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b, DIGIT bits per cycle, LSB-first,
// with start/busy/done handshake. Define SERIAL_SUB_SAT_EN for saturating (clamp-to-0) mode.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled on a rising edge and accepted only in IDLE or DONE;
  // a/b are captured on that same edge; done pulses for one cycle with diff/borrow valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic [DIGIT:0]         dig;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   capture;

  always_comb begin
    // The top bit of the (DIGIT+1)-wide difference is the borrow out of this digit.
    dig       = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, bin_q};
    res_cat   = {dig[DIGIT-1:0], res_q};
    res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) capture = 1'b1;
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_shift;
        bin_d = dig[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          diff_d   = (SAT && dig[DIGIT]) ? '0 : res_shift;
          borrow_d = dig[DIGIT];
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) capture = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      res_d   = '0;
      bin_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign dbg_state = state_q;

endmodule
